// File: rtl/serial_subtractor_if.sv
// Request/response bundle for serial_subtractor: operand request port plus result response port.
// Purely wiring; no latency of its own.
// Optional ovf wire exists only when SERIAL_SUB_OVF_EN is defined.
interface serial_subtractor_if #(
    parameter int WIDTH = 4
);
    logic             start_valid;
    logic             start_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             done_valid;
    logic             done_ready;
`ifdef SERIAL_SUB_OVF_EN
    logic             ovf;
`endif

    // Requester / result consumer side
    modport master (
        output start_valid, a, b, bin, done_ready,
`ifdef SERIAL_SUB_OVF_EN
        input  ovf,
`endif
        input  start_ready, diff, bout, done_valid
    );

    // Subtractor side
    modport slave (
        input  start_valid, a, b, bin, done_ready,
`ifdef SERIAL_SUB_OVF_EN
        output ovf,
`endif
        output start_ready, diff, bout, done_valid
    );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial a - b - bin, LSB first, one full-subtractor cell; SERIAL_SUB_OVF_EN adds signed overflow output.
// Latency: WIDTH cycles from request acceptance to done_valid; issue interval WIDTH+2 cycles.
// Backpressure: result held in DONE until done_ready; start_ready only in IDLE, so requests stall meanwhile.
module serial_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    serial_subtractor_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             br_q, br_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bout_q, bout_d;
`ifdef SERIAL_SUB_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    logic x, y, d_bit, br_nxt;

    // Full-subtractor cell working on the current operand LSBs
    always_comb begin
        x      = a_sh_q[0];
        y      = b_sh_q[0];
        d_bit  = x ^ y ^ br_q;
        br_nxt = (~x & y) | (~(x ^ y) & br_q);
    end

    // Next-state and datapath control; results only move on the BUSY->DONE step
    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        res_d   = res_q;
        br_d    = br_q;
        cnt_d   = cnt_q;
        diff_d  = diff_q;
        bout_d  = bout_q;
`ifdef SERIAL_SUB_OVF_EN
        ovf_d   = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.start_valid) begin
                    a_sh_d  = bus.a;
                    b_sh_d  = bus.b;
                    br_d    = bus.bin;
                    cnt_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                a_sh_d = a_sh_q >> 1;
                b_sh_d = b_sh_q >> 1;
                res_d  = {d_bit, res_q[WIDTH-1:1]};
                br_d   = br_nxt;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    // Counter left as-is so it never wraps on power-of-two widths
                    diff_d  = {d_bit, res_q[WIDTH-1:1]};
                    bout_d  = br_nxt;
`ifdef SERIAL_SUB_OVF_EN
                    // br_q is the borrow into the MSB, br_nxt the borrow out of it
                    ovf_d   = br_q ^ br_nxt;
`endif
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                if (bus.done_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset discards any partial result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            res_q   <= '0;
            br_q    <= 1'b0;
            cnt_q   <= '0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            res_q   <= res_d;
            br_q    <= br_d;
            cnt_q   <= cnt_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
`ifdef SERIAL_SUB_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign bus.start_ready = (state_q == IDLE);
    assign bus.done_valid  = (state_q == DONE);
    assign bus.diff        = diff_q;
    assign bus.bout        = bout_q;
`ifdef SERIAL_SUB_OVF_EN
    assign bus.ovf         = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor (WIDTH=4) with hand-computed results.
// Covers reset, latency, borrow cases, backpressure hold and mid-operation reset.
// Overflow expectations are checked only when SERIAL_SUB_OVF_EN is defined.
module tb_serial_subtractor;
    localparam int WIDTH = 4;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fails;

    serial_subtractor_if #(.WIDTH(WIDTH)) bus ();

    serial_subtractor #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one request and wait for its result without accepting it
    task automatic issue(input logic [3:0] ta, input logic [3:0] tb_v, input logic tbin, input string tag);
        int n;
        n = 0;
        while (!bus.start_ready && n < 20) begin
            tick();
            n++;
        end
        check_val({tag, "_wait_ready"}, 32'(n < 20), 32'd1);
        bus.start_valid = 1'b1;
        bus.a           = ta;
        bus.b           = tb_v;
        bus.bin         = tbin;
        tick();
        bus.start_valid = 1'b0;
        bus.a           = 4'hx;
        bus.b           = 4'hx;
        bus.bin         = 1'bx;
    endtask

    task automatic wait_done(input string tag, output int lat);
        lat = 0;
        while (!bus.done_valid && lat < 20) begin
            tick();
            lat++;
        end
        check_val({tag, "_latency"}, lat, WIDTH);
    endtask

    task automatic run_op(input logic [3:0] ta, input logic [3:0] tb_v, input logic tbin,
                          input logic [3:0] ed, input logic eb, input logic eo, input string tag);
        int lat;
        issue(ta, tb_v, tbin, tag);
        wait_done(tag, lat);
        check_val({tag, "_diff"}, 32'(bus.diff), 32'(ed));
        check_val({tag, "_bout"}, 32'(bus.bout), 32'(eb));
`ifdef SERIAL_SUB_OVF_EN
        check_val({tag, "_ovf"}, 32'(bus.ovf), 32'(eo));
`else
        if (eo === 1'bz) $display("note: unexpected z");
`endif
        bus.done_ready = 1'b1;
        tick();
        bus.done_ready = 1'b0;
        check_val({tag, "_dv_fall"}, 32'(bus.done_valid), 32'd0);
        check_val({tag, "_sr_rise"}, 32'(bus.start_ready), 32'd1);
    endtask

    initial begin
        int lat;
        n_checks        = 0;
        n_fails         = 0;
        rst_n           = 1'b0;
        bus.start_valid = 1'b0;
        bus.a           = '0;
        bus.b           = '0;
        bus.bin         = 1'b0;
        bus.done_ready  = 1'b0;

        // Reset state
        #12;
        check_val("rst_start_ready", 32'(bus.start_ready), 32'd1);
        check_val("rst_done_valid", 32'(bus.done_valid), 32'd0);
        check_val("rst_diff", 32'(bus.diff), 32'd0);
        check_val("rst_bout", 32'(bus.bout), 32'd0);
`ifdef SERIAL_SUB_OVF_EN
        check_val("rst_ovf", 32'(bus.ovf), 32'd0);
`endif
        rst_n = 1'b1;
        tick();
        check_val("post_rst_start_ready", 32'(bus.start_ready), 32'd1);

        // Basic subtraction and borrow cases
        run_op(4'd9, 4'd3, 1'b0, 4'd6,  1'b0, 1'b1, "sub_9_3");
        run_op(4'd3, 4'd9, 1'b0, 4'd10, 1'b1, 1'b1, "sub_3_9");
        run_op(4'd0, 4'd0, 1'b1, 4'd15, 1'b1, 1'b0, "sub_0_0_b1");
        run_op(4'd8, 4'd1, 1'b0, 4'd7,  1'b0, 1'b1, "sub_8_1");
        run_op(4'd5, 4'd2, 1'b0, 4'd3,  1'b0, 1'b0, "sub_5_2");

        // Backpressure: result held while new requests are offered
        issue(4'd9, 4'd3, 1'b0, "bp");
        wait_done("bp", lat);
        for (int i = 0; i < 5; i++) begin
            bus.start_valid = (i % 2 == 0);
            bus.a           = 4'd1;
            bus.b           = 4'd2;
            bus.bin         = 1'b1;
            tick();
            check_val("bp_done_valid", 32'(bus.done_valid), 32'd1);
            check_val("bp_start_ready", 32'(bus.start_ready), 32'd0);
            check_val("bp_diff", 32'(bus.diff), 32'd6);
            check_val("bp_bout", 32'(bus.bout), 32'd0);
        end
        bus.start_valid = 1'b0;
        bus.done_ready  = 1'b1;
        tick();
        bus.done_ready  = 1'b0;
        check_val("bp_release_dv", 32'(bus.done_valid), 32'd0);
        check_val("bp_release_sr", 32'(bus.start_ready), 32'd1);
        check_val("bp_diff_held", 32'(bus.diff), 32'd6);
        tick();
        check_val("bp_no_accept", 32'(bus.start_ready), 32'd1);

        // Mid-operation reset after two BUSY cycles
        issue(4'd8, 4'd1, 1'b0, "mid");
        tick();
        tick();
        check_val("mid_busy_sr", 32'(bus.start_ready), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("mid_rst_sr", 32'(bus.start_ready), 32'd1);
        check_val("mid_rst_dv", 32'(bus.done_valid), 32'd0);
        check_val("mid_rst_diff", 32'(bus.diff), 32'd0);
        check_val("mid_rst_bout", 32'(bus.bout), 32'd0);
`ifdef SERIAL_SUB_OVF_EN
        check_val("mid_rst_ovf", 32'(bus.ovf), 32'd0);
`endif
        #3;
        rst_n = 1'b1;
        tick();
        run_op(4'd15, 4'd15, 1'b1, 4'd15, 1'b1, 1'b0, "sub_15_15_b1");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    // Global watchdog
    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1);
    end
endmodule
